// File: rtl/sga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sga_pkg
// Description : Shared state encodings and debug width for the snake game
//               arcade control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package sga_pkg;

    localparam int SGA_DB_W = 4;

    localparam logic [SGA_DB_W-1:0] c_ST_IDLE      = 4'h0;
    localparam logic [SGA_DB_W-1:0] c_ST_PREPARE   = 4'h1;
    localparam logic [SGA_DB_W-1:0] c_ST_GEN_APPLE = 4'h2;
    localparam logic [SGA_DB_W-1:0] c_ST_RENDER    = 4'h3;
    localparam logic [SGA_DB_W-1:0] c_ST_WAIT_TICK = 4'h4;
    localparam logic [SGA_DB_W-1:0] c_ST_MOVE      = 4'h5;
    localparam logic [SGA_DB_W-1:0] c_ST_CHECK     = 4'h6;
    localparam logic [SGA_DB_W-1:0] c_ST_GROW      = 4'h7;
    localparam logic [SGA_DB_W-1:0] c_ST_PAUSED    = 4'h8;
    localparam logic [SGA_DB_W-1:0] c_ST_WON       = 4'h9;
    localparam logic [SGA_DB_W-1:0] c_ST_LOST      = 4'hA;
    localparam logic [SGA_DB_W-1:0] c_ST_RESPAWN   = 4'hB;

    typedef enum logic [SGA_DB_W-1:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_PREPARE   = c_ST_PREPARE,
        ST_GEN_APPLE = c_ST_GEN_APPLE,
        ST_RENDER    = c_ST_RENDER,
        ST_WAIT_TICK = c_ST_WAIT_TICK,
        ST_MOVE      = c_ST_MOVE,
        ST_CHECK     = c_ST_CHECK,
        ST_GROW      = c_ST_GROW,
        ST_PAUSED    = c_ST_PAUSED,
        ST_WON       = c_ST_WON,
        ST_LOST      = c_ST_LOST,
        ST_RESPAWN   = c_ST_RESPAWN
    } sga_state_e;

endpackage
`default_nettype wire

// File: rtl/sga_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sga_game_ctrl_if
// Description : Control/status bundle between the game controller (master)
//               and the datapath, apple generator and renderer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sga_game_ctrl_if #(
    parameter int SIZE_W = 4
);
    import sga_pkg::*;

    logic                start;
    logic                pause;
    logic                tick;
    logic                is_at_apple;
    logic                is_at_border;
    logic                is_at_body;
    logic                apple_valid;
    logic                render_done;
    logic                apple_req;
    logic                render_start;
    logic                move;
    logic                clear_body;
    logic [SIZE_W-1:0]   size;
    logic [1:0]          lives;
    logic                paused;
    logic                won;
    logic                lost;
    logic                finished;
    logic [SGA_DB_W-1:0] db_state;

    modport master (
        input  start, pause, tick, is_at_apple, is_at_border, is_at_body,
               apple_valid, render_done,
        output apple_req, render_start, move, clear_body, size, lives,
               paused, won, lost, finished, db_state
    );

    modport slave (
        output start, pause, tick, is_at_apple, is_at_border, is_at_body,
               apple_valid, render_done,
        input  apple_req, render_start, move, clear_body, size, lives,
               paused, won, lost, finished, db_state
    );

endinterface
`default_nettype wire

// File: rtl/sga_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sga_sat_counter
// Description : Loadable up/down counter that saturates at 0 and MAX_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module sga_sat_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15
) (
    input  wire logic             clock,
    input  wire logic             restart_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             inc,
    input  wire logic             dec,
    output logic      [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (inc && !dec) begin
            if (r_count < c_MAX) r_count <= r_count + c_ONE;
        end else if (dec && !inc) begin
            if (r_count != '0) r_count <= r_count - c_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sga_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sga_game_ctrl
// Description : Snake game arcade control FSM with size/lives counters.
//               Define SGA_LIVES_EN to enable multiple lives with respawn.
// Revision    : 1.0 - initial release
// ============================================================================
module sga_game_ctrl
    import sga_pkg::*;
#(
    parameter int SIZE_W    = 4,
    parameter int INIT_SIZE = 3,
    parameter int MAX_SIZE  = 15,
    parameter int LIVES     = 3
) (
    input  wire logic        clock,
    input  wire logic        restart_n,
    sga_game_ctrl_if.master  bus
);

    localparam logic [SIZE_W-1:0] c_INIT_SIZE = SIZE_W'(INIT_SIZE);
    localparam logic [SIZE_W-1:0] c_MAX_SIZE  = SIZE_W'(MAX_SIZE);
    localparam logic [SIZE_W-1:0] c_SIZE_ONE  = {{(SIZE_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        c_LIVES     = 2'(LIVES);

    sga_state_e        r_state;
    sga_state_e        w_state_next;
    logic              r_render_start;
    logic              w_size_load;
    logic              w_size_inc;
    logic              w_lives_load;
    logic              w_lives_dec;
    logic              w_hit;
    logic [SIZE_W-1:0] w_size;
    logic [SIZE_W-1:0] w_size_plus;
    logic [1:0]        w_lives;

`ifdef SGA_LIVES_EN
    // Distinguishes PREPARE_KEEP from PREPARE; both report the PREPARE code.
    logic r_keep_lives;
    logic w_keep_next;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) r_keep_lives <= 1'b0;
        else            r_keep_lives <= w_keep_next;
    end
`endif

    assign w_hit       = bus.is_at_border | bus.is_at_body;
    assign w_size_plus = w_size + c_SIZE_ONE;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            r_state        <= ST_IDLE;
            r_render_start <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_render_start <= (w_state_next == ST_RENDER) && (r_state != ST_RENDER);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_size_load  = 1'b0;
        w_size_inc   = 1'b0;
        w_lives_load = 1'b0;
        w_lives_dec  = 1'b0;
`ifdef SGA_LIVES_EN
        w_keep_next  = r_keep_lives;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_next = ST_PREPARE;
`ifdef SGA_LIVES_EN
                w_keep_next = 1'b0;
`endif
            end
            ST_PREPARE: begin
                w_state_next = ST_GEN_APPLE;
                w_size_load  = 1'b1;
`ifdef SGA_LIVES_EN
                w_lives_load = !r_keep_lives;
                w_keep_next  = 1'b0;
`endif
            end
            ST_GEN_APPLE: if (bus.apple_valid) w_state_next = ST_RENDER;
            ST_RENDER:    if (bus.render_done) w_state_next = ST_WAIT_TICK;
            ST_WAIT_TICK: begin
                if (bus.pause)     w_state_next = ST_PAUSED;
                else if (bus.tick) w_state_next = ST_MOVE;
            end
            ST_MOVE:      w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (w_hit) begin
`ifdef SGA_LIVES_EN
                    if (w_lives > 2'd1) begin
                        w_state_next = ST_RESPAWN;
                    end else begin
                        w_state_next = ST_LOST;
                        w_lives_dec  = 1'b1;
                    end
`else
                    w_state_next = ST_LOST;
`endif
                end else if (bus.is_at_apple) begin
                    w_state_next = ST_GROW;
                end else begin
                    w_state_next = ST_RENDER;
                end
            end
            ST_GROW: begin
                w_size_inc   = 1'b1;
                w_state_next = (w_size_plus == c_MAX_SIZE) ? ST_WON : ST_GEN_APPLE;
            end
            // Resuming redraws the frame first so the player sees the board before play continues.
            ST_PAUSED: if (bus.start && !bus.pause) w_state_next = ST_RENDER;
            ST_WON, ST_LOST: begin
                if (bus.start) w_state_next = ST_PREPARE;
`ifdef SGA_LIVES_EN
                w_keep_next = 1'b0;
`endif
            end
            ST_RESPAWN: begin
                w_state_next = ST_PREPARE;
                w_lives_dec  = 1'b1;
`ifdef SGA_LIVES_EN
                w_keep_next  = 1'b1;
`endif
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    sga_sat_counter #(
        .WIDTH   (SIZE_W),
        .MAX_VAL (MAX_SIZE)
    ) u_size_cnt (
        .clock      (clock),
        .restart_n  (restart_n),
        .load       (w_size_load),
        .load_value (c_INIT_SIZE),
        .inc        (w_size_inc),
        .dec        (1'b0),
        .count      (w_size)
    );

    // Without lives the load/dec controls stay low, so this counter holds 0.
    sga_sat_counter #(
        .WIDTH   (2),
        .MAX_VAL (3)
    ) u_lives_cnt (
        .clock      (clock),
        .restart_n  (restart_n),
        .load       (w_lives_load),
        .load_value (c_LIVES),
        .inc        (1'b0),
        .dec        (w_lives_dec),
        .count      (w_lives)
    );

    assign bus.apple_req    = (r_state == ST_GEN_APPLE);
    assign bus.render_start = r_render_start;
    assign bus.move         = (r_state == ST_MOVE);
    assign bus.clear_body   = (r_state == ST_IDLE) || (r_state == ST_PREPARE) ||
                              (r_state == ST_RESPAWN);
    assign bus.size         = w_size;
    assign bus.lives        = w_lives;
    assign bus.paused       = (r_state == ST_PAUSED);
    assign bus.won          = (r_state == ST_WON);
    assign bus.lost         = (r_state == ST_LOST);
    assign bus.finished     = (r_state == ST_WON) || (r_state == ST_LOST);
    assign bus.db_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sga_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sga_game_ctrl
// Description : Randomized game sessions against a transaction-level model of
//               the snake game controller (size, lives, outcome per tick).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sga_game_ctrl;

    localparam int SIZE_W    = 4;
    localparam int INIT_SIZE = 3;
    localparam int MAX_SIZE  = 5;
    localparam int LIVES     = 2;
`ifdef SGA_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    localparam int D_IDLE = 0, D_PREPARE = 1, D_GEN = 2, D_RENDER = 3, D_WAIT = 4,
                   D_MOVE = 5, D_CHECK = 6, D_GROW = 7, D_PAUSED = 8, D_WON = 9,
                   D_LOST = 10, D_RESPAWN = 11;
    localparam int R_APPLE = 0, R_RENDER = 1, R_OVER = 2;

    logic clock     = 1'b0;
    logic restart_n = 1'b0;

    sga_game_ctrl_if #(.SIZE_W(SIZE_W)) bus ();

    sga_game_ctrl #(
        .SIZE_W    (SIZE_W),
        .INIT_SIZE (INIT_SIZE),
        .MAX_SIZE  (MAX_SIZE),
        .LIVES     (LIVES)
    ) dut (
        .clock     (clock),
        .restart_n (restart_n),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int m_size   = 0;
    int m_lives  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input int code);
        check_eq(tag, 32'(bus.db_state), code);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_state("prepare", D_PREPARE);
        check_eq("clear_body_prepare", 32'(bus.clear_body), 1);
        step();
        m_size  = INIT_SIZE;
        m_lives = LIVES_EN ? LIVES : 0;
        check_state("gen_apple", D_GEN);
        check_eq("apple_req", 32'(bus.apple_req), 1);
        check_eq("size_loaded", 32'(bus.size), m_size);
        check_eq("lives_loaded", 32'(bus.lives), m_lives);
    endtask

    task automatic apple_phase();
        int d;
        d = $urandom_range(0, 3);
        repeat (d) begin
            bus.tick = 1'($urandom_range(0, 1));
            step();
            check_state("gen_hold", D_GEN);
        end
        bus.tick        = 1'b0;
        bus.apple_valid = 1'b1;
        step();
        bus.apple_valid = 1'b0;
        check_state("render_entry", D_RENDER);
        check_eq("render_start_pulse", 32'(bus.render_start), 1);
    endtask

    task automatic render_wait(input int min_d);
        int d;
        d = $urandom_range(min_d, 4);
        repeat (d) begin
            bus.tick = 1'($urandom_range(0, 1));
            step();
            check_state("render_hold", D_RENDER);
            check_eq("render_start_once", 32'(bus.render_start), 0);
            check_eq("no_pause_in_render", 32'(bus.paused), 0);
        end
        bus.tick        = 1'b0;
        bus.render_done = 1'b1;
        step();
        bus.render_done = 1'b0;
        check_state("wait_tick_entry", D_WAIT);
    endtask

    task automatic render_phase(input bit with_pause);
        if (!with_pause) begin
            render_wait(0);
        end else begin
            bus.pause = 1'b1;
            render_wait(2);
            check_eq("no_early_pause", 32'(bus.paused), 0);
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            check_state("pause_beats_tick", D_PAUSED);
            check_eq("paused_flag", 32'(bus.paused), 1);
            check_eq("no_move_paused", 32'(bus.move), 0);
            bus.start = 1'b1;
            step();
            check_state("pause_held", D_PAUSED);
            bus.pause = 1'b0;
            step();
            bus.start = 1'b0;
            check_state("resume_render", D_RENDER);
            check_eq("resume_render_start", 32'(bus.render_start), 1);
            check_eq("resume_size", 32'(bus.size), m_size);
            render_wait(0);
        end
    endtask

    task automatic tick_phase();
        int idle;
        idle = $urandom_range(0, 2);
        repeat (idle) begin
            step();
            check_state("wait_idle", D_WAIT);
        end
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        check_eq("move_pulse", 32'(bus.move), 1);
        check_state("move", D_MOVE);
        step();
        check_state("check", D_CHECK);
        check_eq("move_single", 32'(bus.move), 0);
    endtask

    task automatic resolve(input bit a, input bit b, input bit c, output int result);
        bus.is_at_apple  = a;
        bus.is_at_border = b;
        bus.is_at_body   = c;
        step();
        bus.is_at_apple  = 1'b0;
        bus.is_at_border = 1'b0;
        bus.is_at_body   = 1'b0;
        if (b || c) begin
            if (LIVES_EN && m_lives > 1) begin
                check_state("respawn", D_RESPAWN);
                check_eq("respawn_clear", 32'(bus.clear_body), 1);
                step();
                m_lives--;
                check_state("prepare_keep", D_PREPARE);
                check_eq("lives_after_respawn", 32'(bus.lives), m_lives);
                step();
                m_size = INIT_SIZE;
                check_state("respawn_gen", D_GEN);
                check_eq("respawn_size", 32'(bus.size), m_size);
                check_eq("respawn_lives_kept", 32'(bus.lives), m_lives);
                result = R_APPLE;
            end else begin
                m_lives = 0;
                check_state("lost", D_LOST);
                check_eq("lost_flag", 32'(bus.lost), 1);
                check_eq("lost_finished", 32'(bus.finished), 1);
                check_eq("lost_not_won", 32'(bus.won), 0);
                check_eq("lost_size", 32'(bus.size), m_size);
                check_eq("lost_lives", 32'(bus.lives), m_lives);
                result = R_OVER;
            end
        end else if (a) begin
            check_state("grow", D_GROW);
            step();
            m_size++;
            check_eq("grown_size", 32'(bus.size), m_size);
            if (m_size == MAX_SIZE) begin
                check_state("won", D_WON);
                check_eq("won_flag", 32'(bus.won), 1);
                check_eq("won_finished", 32'(bus.finished), 1);
                result = R_OVER;
            end else begin
                check_state("grow_gen", D_GEN);
                result = R_APPLE;
            end
        end else begin
            check_state("no_hit_render", D_RENDER);
            check_eq("no_hit_render_start", 32'(bus.render_start), 1);
            result = R_RENDER;
        end
    endtask

    // mode 0 random, 1 apples only, 2 apple+body, 3 border only, 4 pause then random
    task automatic play_game(input int mode);
        int result, iter, r;
        bit a, b, c, first;
        start_game();
        result = R_APPLE;
        iter   = 0;
        first  = 1'b1;
        while (result != R_OVER && iter < 40) begin
            iter++;
            if (result == R_APPLE) apple_phase();
            render_phase((mode == 4 && first) || (mode == 0 && $urandom_range(0, 3) == 0));
            first = 1'b0;
            tick_phase();
            a = 1'b0; b = 1'b0; c = 1'b0;
            case (mode)
                1: a = 1'b1;
                2: begin a = 1'b1; c = 1'b1; end
                3: b = 1'b1;
                default: begin
                    r = $urandom_range(0, 9);
                    if (r >= 5 && r <= 7) a = 1'b1;
                    if (r == 8) begin b = 1'b1; a = 1'($urandom_range(0, 1)); end
                    if (r == 9) begin c = 1'b1; a = 1'($urandom_range(0, 1)); end
                end
            endcase
            resolve(a, b, c, result);
        end
        check_eq("game_bounded", 32'(result == R_OVER), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        bus.tick         = 1'b0;
        bus.is_at_apple  = 1'b0;
        bus.is_at_border = 1'b0;
        bus.is_at_body   = 1'b0;
        bus.apple_valid  = 1'b0;
        bus.render_done  = 1'b0;

        #2;
        check_state("reset_state", D_IDLE);
        check_eq("reset_size", 32'(bus.size), 0);
        check_eq("reset_lives", 32'(bus.lives), 0);
        check_eq("reset_won", 32'(bus.won), 0);
        check_eq("reset_lost", 32'(bus.lost), 0);
        check_eq("reset_paused", 32'(bus.paused), 0);
        check_eq("reset_finished", 32'(bus.finished), 0);
        check_eq("reset_move", 32'(bus.move), 0);
        check_eq("reset_render_start", 32'(bus.render_start), 0);
        check_eq("reset_apple_req", 32'(bus.apple_req), 0);

        @(negedge clock);
        restart_n = 1'b1;
        step();
        step();
        check_state("idle_without_start", D_IDLE);

        play_game(1);
        play_game(2);
        play_game(3);
        play_game(4);

        // Asynchronous reset while the renderer is busy.
        start_game();
        apple_phase();
        #2 restart_n = 1'b0;
        #1;
        m_size  = 0;
        m_lives = 0;
        check_state("async_reset_state", D_IDLE);
        check_eq("async_reset_size", 32'(bus.size), m_size);
        check_eq("async_reset_lives", 32'(bus.lives), m_lives);
        check_eq("async_reset_render_start", 32'(bus.render_start), 0);
        @(negedge clock);
        restart_n = 1'b1;
        step();
        check_state("idle_after_reset", D_IDLE);

        for (int g = 0; g < 10; g++) play_game(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
